// File: rtl/field_pack_seq.sv
// field_pack_seq: extracts NFIELDS alternating-width fields from a strided word and packs them densely, one field per cycle.
// Optional parity output out_par is enabled by defining FIELD_PACK_PARITY_EN.
module field_pack_seq #(
  parameter int NFIELDS = 8,
  parameter int EVEN_W  = 3,
  parameter int ODD_W   = 4,
  parameter int STRIDE  = 7,
  parameter int IN_W    = 128,
  parameter int OUT_W   = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
`ifdef FIELD_PACK_PARITY_EN
  output logic             out_par,
`endif
  output logic             busy
);
  localparam int PAIR_W = EVEN_W + ODD_W;
  localparam int PACK_W = (NFIELDS / 2) * PAIR_W;
  localparam int IDX_W  = $clog2(NFIELDS);

  if (NFIELDS % 2 != 0 || NFIELDS < 2 || STRIDE < PAIR_W ||
      (NFIELDS / 2 - 1) * STRIDE + PAIR_W > IN_W || PACK_W > OUT_W) begin : g_bad_cfg
    $error("field_pack_seq: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, PACK, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IN_W-1:0]    hold_q, hold_d;
  logic [PACK_W-1:0]  acc_q, acc_d;
  logic [PACK_W-1:0]  field_at [NFIELDS];
  logic               unused_hold;

  // each field pre-shifted to its packed position; PACK ORs in one per cycle
  for (genvar f = 0; f < NFIELDS; f++) begin : g_field
    localparam int W   = (f % 2) ? ODD_W : EVEN_W;
    localparam int SRC = (f / 2) * STRIDE + (f % 2) * EVEN_W;
    localparam int OFF = (f / 2) * PAIR_W + (f % 2) * EVEN_W;
    assign field_at[f] = PACK_W'(hold_q[SRC +: W]) << OFF;
  end

  assign unused_hold = ^hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    acc_d    = acc_q;
    in_ready = state_q == IDLE || (state_q == DONE && out_ready);
    if (in_ready && in_valid) begin
      state_d = PACK;
      hold_d  = in;
      acc_d   = '0;
      idx_d   = '0;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end else if (state_q == PACK) begin
      acc_d   = acc_q | field_at[idx_q];
      state_d = idx_q == IDX_W'(NFIELDS - 1) ? DONE : PACK;
      idx_d   = idx_q == IDX_W'(NFIELDS - 1) ? '0 : idx_q + 1'b1;
    end
  end

  assign out_valid = state_q == DONE;
  assign busy      = state_q == PACK;
  assign out       = out_valid ? OUT_W'(acc_q) : '0;
`ifdef FIELD_PACK_PARITY_EN
  assign out_par   = out_valid & (^acc_q);
`endif
endmodule

// File: tb/tb_field_pack_seq.sv
// tb_field_pack_seq: randomized check of field_pack_seq (STRIDE 7 and 8 instances in lockstep) against a bit-level packing model.
module tb_field_pack_seq;
  logic         clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [127:0] in_w = '0;
  logic         in_ready, out_valid, busy, in_ready8, out_valid8, busy8;
  logic [127:0] out7, out8;
  int           checks = 0, errors = 0;
`ifdef FIELD_PACK_PARITY_EN
  logic         par7, par8;
`endif

  field_pack_seq dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in(in_w),
    .out_valid(out_valid), .out_ready(out_ready), .out(out7),
`ifdef FIELD_PACK_PARITY_EN
    .out_par(par7),
`endif
    .busy(busy));

  field_pack_seq #(.STRIDE(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8), .in(in_w),
    .out_valid(out_valid8), .out_ready(out_ready), .out(out8),
`ifdef FIELD_PACK_PARITY_EN
    .out_par(par8),
`endif
    .busy(busy8));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] w, input int stride);
    logic [127:0] r;
    int p, wd, src;
    r = '0;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      wd  = (i % 2) ? 4 : 3;
      src = (i / 2) * stride + ((i % 2) ? 3 : 0);
      for (int b = 0; b < wd; b++) begin
        r[p] = w[src + b];
        p++;
      end
    end
    return r;
  endfunction

  task automatic check_outputs(input string tag, input logic [127:0] w);
    chk({tag, "_out7"}, out7, model(w, 7));
    chk({tag, "_out8"}, out8, model(w, 8));
    chk({tag, "_busy"}, {busy, busy8}, 2'b00);
`ifdef FIELD_PACK_PARITY_EN
    chk({tag, "_par7"}, par7, ^model(w, 7));
    chk({tag, "_par8"}, par8, ^model(w, 8));
`endif
  endtask

  task automatic accept(input logic [127:0] w);
    in_w = w;
    in_valid = 1;
    chk("accept_rdy", {in_ready, in_ready8}, 2'b11);
    @(posedge clk); #1;
    in_valid = 0;
    in_w = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 9);
    chk("valid8", out_valid8, 1);
  endtask

  task automatic release_out();
    out_ready = 1;
    #1 chk("release_rdy", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 0;
    chk("idle_valid", {out_valid, out_valid8}, 2'b00);
    chk("idle_out", out7, '0);
  endtask

  initial begin
    logic [127:0] w, w2, held;
    logic [127:0] dir [3];
    int n;
    dir[0] = 128'h0123456789ABCDEF_0123456789ABCDEF;
    dir[1] = 128'h7F7F7F7F;
    dir[2] = 128'h08080808;
    #1;
    chk("rst_out", out7, '0);
    chk("rst_valid", {out_valid, out_valid8}, 2'b00);
    chk("rst_busy", {busy, busy8}, 2'b00);
    #11 rst_n = 1;
    @(posedge clk); #1;
    chk("rst_rdy", in_ready, 1);
    for (int k = 0; k < 23; k++) begin
      w = k < 3 ? dir[k] : {$urandom, $urandom, $urandom, $urandom};
      accept(w);
      wait_valid(n);
      check_outputs("txn", w);
      if (k == 0) chk("req031", out7, 128'h09ABCDEF);
      if (k == 1) chk("req032", out8, 128'h0FFFFFFF);
      if (k == 2) chk("req033", out8, 128'h01020408);
      held = out7;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        chk("stall_out", out7, held);
        chk("stall_rdy", in_ready, 0);
      end
      release_out();
    end
    w  = {$urandom, $urandom, $urandom, $urandom};
    w2 = {$urandom, $urandom, $urandom, $urandom};
    accept(w);
    wait_valid(n);
    in_w = w2;
    in_valid = 1;
    repeat (5) begin
      chk("b2b_rdy", in_ready, 0);
      chk("b2b_out", out7, model(w, 7));
      @(posedge clk); #1;
    end
    out_ready = 1;
    #1 chk("b2b_take", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 0;
    in_valid = 0;
    in_w = '1;
    chk("b2b_pack", busy, 1);
    wait_valid(n);
    check_outputs("b2b", w2);
    release_out();
    accept({$urandom, $urandom, $urandom, $urandom});
    repeat (4) @(posedge clk);
    #1 chk("mid_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", {out_valid, out_valid8}, 2'b00);
    chk("mid_rst_busy", {busy, busy8}, 2'b00);
    chk("mid_rst_out", out7 | out8, '0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst_rdy", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);
    w = {$urandom, $urandom, $urandom, $urandom};
    accept(w);
    wait_valid(n);
    check_outputs("post_rst", w);
    release_out();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
